queen_out_checker: RTL and testbench
====================================

// Module: queen_out_checker
// PURPOSE
//  Receive-side counterpart of the N-queens solver output stream. Snoops the solver input stream
//  (preset queens on in_valid/col/row, count on in_valid_num/in_num), captures the out_valid/out answer.
//  Then checks the answer for range, length, row/diagonal conflicts and preset agreement.
//  Sits beside the solver core; reports one pass/fail verdict per answer.
// PARAMETERS
//  N      12  board size; answer is N rows, one per column 0..N-1 (N <= 16)
//  MAXP    8  max preset queens stored (in_num is 3 bits, so 1..7 are used)
// PORTS
//  clk           in   1  clock, rising edge
//  rst_n         in   1  synchronous reset, active low
//  in_valid      in   1  preset queen valid (col,row meaningful)
//  in_valid_num  in   1  in_num valid (single cycle, coincides with first in_valid)
//  col           in   4  preset queen column
//  row           in   4  preset queen row
//  in_num        in   3  number of preset queens
//  out_valid     in   1  solver answer valid
//  out           in   4  row of queen in column k (k = k-th out_valid cycle)
//  chk_done      out  1  one-cycle pulse: verdict valid
//  chk_pass      out  1  1 = answer legal; held from chk_done until next chk_done
//  chk_err       out  3  0 ok,1 length,2 range,3 row/diag conflict,4 preset mismatch; held like chk_pass
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state IDLE, counters 0, chk_done=0, chk_pass=0, chk_err=0.
//  Reset mid-operation aborts everything; no verdict is produced for the aborted answer.
//  FSM: IDLE -> PRESET on in_valid; PRESET: store {col,row} per in_valid cycle (first MAXP kept),
//   latch in_num when in_valid_num; in_valid low -> WAIT. IDLE/WAIT -> COLLECT on out_valid.
//  COLLECT: sol[k]<=out, k++ each out_valid cycle; k==N-1 captured -> PAIR.
//   out_valid low before N values -> REPORT, err=1. out>=N -> sticky range flag (err=2 unless err=1).
//  PAIR: one pair (i<j) per cycle, i=0..N-2, j=i+1..N-1 (N(N-1)/2 cycles);
//   conflict if sol[i]==sol[j] or |sol[i]-sol[j]|==j-i (5-bit unsigned diff). First conflict -> REPORT, err=3.
//  PRESET_CHK: one preset per cycle, p=0..min(in_num,MAXP)-1; sol[pcol[p]]!=prow[p] -> err=4.
//   pcol>=N counts as mismatch. in_num=0 or no in_valid_num -> step skipped.
//  REPORT: chk_done=1 one cycle, chk_pass=(err==0), chk_err=err; -> IDLE. Error precedence 1>2>3>4.
//  Range error: PAIR/PRESET_CHK skipped, REPORT directly after COLLECT.
//  out_valid beyond N cycles: ignored (no effect, no error). in_valid outside IDLE/PRESET: ignored.
//  Preset capture clears on entry to PRESET; an answer without a preceding preset phase checks no presets.
//  Latency: last out_valid -> chk_done = N(N-1)/2 + P + 2 cycles worst case (P = presets checked).
//  Simultaneous in_valid and out_valid in IDLE: out_valid wins (COLLECT), in_valid ignored.
// TESTING
//  1 N=12, no presets, answer 0,2,4,7,9,11,5,10,1,6,8,3 -> chk_done once, pass=1, err=0, after 68 cycles.
//  2 Same answer, preset (0,0) and (3,7), in_num=2 -> pass=1; preset (3,6) instead -> pass=0, err=4.
//  3 Answer with sol[2]=sol[5]=4 -> pass=0, err=3; sol[0]=0, sol[1]=1 (diagonal) -> err=3.
//  4 out_valid drops after 7 values -> chk_done the next cycle, pass=0, err=1; out=13 in column 4 -> err=2.
//  5 rst_n low for 1 cycle mid-PAIR -> chk_done never pulses, outputs 0; next legal answer -> pass=1.
//  6 Back-to-back answers, legal then conflicting -> two chk_done pulses; verdict held in between.

Source files
------------

// File: rtl/queen_out_checker.sv
// Receive-side checker for the N-queens solver: snoops the preset stream, captures the
// answer, then verifies range, length, row/diagonal conflicts and preset agreement.
module queen_out_checker #(
  parameter int N    = 12,
  parameter int MAXP = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       in_valid_num,
  input  logic [3:0] col,
  input  logic [3:0] row,
  input  logic [2:0] in_num,
  input  logic       out_valid,
  input  logic [3:0] out,
  output logic       chk_done,
  output logic       chk_pass,
  output logic [2:0] chk_err
);
  localparam int PIW = (MAXP > 1) ? $clog2(MAXP) : 1;
  localparam int PCW = $clog2(MAXP + 1);
  localparam logic [4:0]     NL5   = 5'(N);
  localparam logic [3:0]     NM1   = 4'(N - 1);
  localparam logic [3:0]     NM2   = 4'(N - 2);
  localparam logic [PCW-1:0] MAXPC = PCW'(MAXP);

  localparam logic [2:0] E_OK    = 3'd0;
  localparam logic [2:0] E_LEN   = 3'd1;
  localparam logic [2:0] E_RANGE = 3'd2;
  localparam logic [2:0] E_CONF  = 3'd3;
  localparam logic [2:0] E_PRE   = 3'd4;

  typedef enum logic [2:0] {
    IDLE, PRESET, WAIT, COLLECT, PAIR, PCHK, REPORT
  } state_t;

  state_t               state, nstate;
  logic [N-1:0][3:0]    sol;
  logic [MAXP-1:0][3:0] pcol, prow;
  logic [PCW-1:0]       pcnt, p, pn_eff;
  logic [2:0]           pnum, err, err_next;
  logic                 have_num, range_f;
  logic [3:0]           k, i, j, pc_sel;
  logic [4:0]           diff;
  logic                 start, oor, conflict, pmis;

  assign oor   = {1'b0, out} >= NL5;
  assign start = ((state == IDLE) || (state == WAIT)) && out_valid;

  // Pair (i,j) is attacked if same row or row distance equals column distance.
  always_comb begin
    diff = ({1'b0, sol[i]} >= {1'b0, sol[j]}) ? ({1'b0, sol[i]} - {1'b0, sol[j]})
                                              : ({1'b0, sol[j]} - {1'b0, sol[i]});
    conflict = (sol[i] == sol[j]) || (diff == {1'b0, 4'(j - i)});
  end

  always_comb begin
    pc_sel = pcol[p[PIW-1:0]];
    pmis   = ({1'b0, pc_sel} >= NL5) || (sol[pc_sel] != prow[p[PIW-1:0]]);
    pn_eff = (PCW'(pnum) > MAXPC) ? MAXPC : PCW'(pnum);
  end

  always_comb begin
    nstate   = state;
    err_next = err;
    case (state)
      IDLE: begin
        if (out_valid) begin
          nstate   = COLLECT;
          err_next = E_OK;
        end else if (in_valid) begin
          nstate = PRESET;
        end
      end
      PRESET: if (!in_valid) nstate = WAIT;
      WAIT: begin
        if (out_valid) begin
          nstate   = COLLECT;
          err_next = E_OK;
        end
      end
      COLLECT: begin
        if (!out_valid) begin
          nstate   = REPORT;
          err_next = E_LEN;
        end else if (k == NM1) begin
          if (range_f || oor) begin
            nstate   = REPORT;
            err_next = E_RANGE;
          end else begin
            nstate = PAIR;
          end
        end
      end
      PAIR: begin
        if (conflict) begin
          nstate   = REPORT;
          err_next = E_CONF;
        end else if ((i == NM2) && (j == NM1)) begin
          nstate = (have_num && (pnum != 3'd0)) ? PCHK : REPORT;
        end
      end
      PCHK: begin
        if (pmis) begin
          nstate   = REPORT;
          err_next = E_PRE;
        end else if ((p + PCW'(1)) == pn_eff) begin
          nstate = REPORT;
        end
      end
      REPORT:  nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      k        <= '0;
      i        <= '0;
      j        <= '0;
      p        <= '0;
      pcnt     <= '0;
      pnum     <= '0;
      have_num <= 1'b0;
      range_f  <= 1'b0;
      err      <= E_OK;
      chk_done <= 1'b0;
      chk_pass <= 1'b0;
      chk_err  <= E_OK;
    end else begin
      state    <= nstate;
      err      <= err_next;
      chk_done <= 1'b0;
      if (start) begin
        sol[0]  <= out;
        k       <= 4'd1;
        range_f <= oor;
        i       <= 4'd0;
        j       <= 4'd1;
        p       <= '0;
      end
      case (state)
        IDLE: begin
          // First preset arrives on the IDLE cycle; the capture restarts from scratch.
          if (!out_valid && in_valid) begin
            pcol     <= '0;
            prow     <= '0;
            pcol[0]  <= col;
            prow[0]  <= row;
            pcnt     <= PCW'(1);
            have_num <= in_valid_num;
            pnum     <= in_valid_num ? in_num : 3'd0;
          end
        end
        PRESET: begin
          if (in_valid) begin
            if (pcnt < MAXPC) begin
              pcol[pcnt[PIW-1:0]] <= col;
              prow[pcnt[PIW-1:0]] <= row;
              pcnt                <= pcnt + PCW'(1);
            end
            if (in_valid_num) begin
              have_num <= 1'b1;
              pnum     <= in_num;
            end
          end
        end
        COLLECT: begin
          if (out_valid) begin
            sol[k]  <= out;
            k       <= k + 4'd1;
            range_f <= range_f | oor;
          end
        end
        PAIR: begin
          if (!conflict) begin
            if (j == NM1) begin
              i <= i + 4'd1;
              j <= i + 4'd2;
            end else begin
              j <= j + 4'd1;
            end
          end
        end
        PCHK: p <= p + PCW'(1);
        REPORT: begin
          chk_done <= 1'b1;
          chk_pass <= (err == E_OK);
          chk_err  <= err;
          have_num <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_queen_out_checker.sv
// Bench for queen_out_checker: table of directed answers plus randomized answers
// scored against a rule-level model of the verdict and its latency.
module tb_queen_out_checker;
  localparam int N = 12;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0, in_valid_num = 1'b0, out_valid = 1'b0;
  logic [3:0] col = '0, row = '0, out = '0;
  logic [2:0] in_num = '0;
  logic       chk_done, chk_pass;
  logic [2:0] chk_err;

  always #5 clk = ~clk;

  queen_out_checker #(.N(N), .MAXP(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_valid_num(in_valid_num),
    .col(col), .row(row), .in_num(in_num), .out_valid(out_valid), .out(out),
    .chk_done(chk_done), .chk_pass(chk_pass), .chk_err(chk_err)
  );

  typedef struct {
    logic [11:0][3:0] ans;
    int               nvals;
    int               extra;
    int               npre;
    logic [9:0][3:0]  pc;
    logic [9:0][3:0]  pr;
    logic [2:0]       num;
    bit               send_num;
    bit               collide;
    bit               ep;
    logic [2:0]       ee;
  } vec_t;

  int               vectors = 0, miscompares = 0;
  bit               hold_pass = 1'b0;
  logic [2:0]       hold_err = '0;
  logic [11:0][3:0] L;
  int               base[12] = '{0, 2, 4, 7, 9, 11, 5, 10, 1, 6, 8, 3};
  vec_t             tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t dflt();
    vec_t v;
    v.ans = L; v.nvals = N; v.extra = 0; v.npre = 0;
    v.pc = '0; v.pr = '0; v.num = '0; v.send_num = 1'b0; v.collide = 1'b0;
    v.ep = 1'b1; v.ee = 3'd0;
    return v;
  endfunction

  // Verdict straight from the rules; latency counted in clock edges from the edge
  // that samples the last answer value to the edge that raises chk_done.
  function automatic void model(input vec_t v, output bit pass, output logic [2:0] err,
                                output int lat);
    int q, nchk, a, b, npairs;
    pass = 1'b0; err = 3'd0; lat = 0;
    npairs = N * (N - 1) / 2;
    if (v.nvals < N) begin err = 3'd1; lat = 3; return; end
    for (int c = 0; c < N; c++)
      if (v.ans[c] >= N) begin err = 3'd2; lat = 2; return; end
    q = 0;
    for (int x = 0; x < N - 1; x++)
      for (int y = x + 1; y < N; y++) begin
        a = int'(v.ans[x]); b = int'(v.ans[y]);
        if (a == b || ((a > b) ? a - b : b - a) == y - x) begin
          err = 3'd3; lat = q + 3; return;
        end
        q++;
      end
    nchk = (v.npre > 0 && v.send_num) ? int'(v.num) : 0;
    for (int r = 0; r < nchk; r++)
      if (v.pc[r] >= N || v.ans[v.pc[r]] != v.pr[r]) begin
        err = 3'd4; lat = npairs + r + 3; return;
      end
    pass = 1'b1;
    lat  = npairs + nchk + 2;
  endfunction

  task automatic run(input vec_t v, input bit ep, input logic [2:0] ee, input int lat,
                     input string nm);
    int m;
    bit seen;
    chk($sformatf("%s held_pass", nm), chk_pass, hold_pass);
    chk($sformatf("%s held_err", nm), chk_err, hold_err);
    if (v.npre > 0) begin
      for (int n = 0; n < v.npre; n++) begin
        in_valid = 1'b1; col = v.pc[n]; row = v.pr[n];
        in_valid_num = (n == 0) && v.send_num; in_num = v.num;
        @(posedge clk); #1;
      end
      in_valid = 1'b0; in_valid_num = 1'b0;
      @(posedge clk); #1;
    end
    for (int n = 0; n < v.nvals; n++) begin
      out_valid = 1'b1; out = v.ans[n];
      if (v.collide) begin
        in_valid = 1'b1; in_valid_num = 1'b1; in_num = 3'd7;
        col = 4'($urandom); row = 4'($urandom);
      end
      if (n < v.nvals - 1) begin @(posedge clk); #1; end
    end
    seen = 1'b0; m = 0;
    while (!seen && m < 300) begin
      @(posedge clk); #1; m++;
      in_valid = 1'b0; in_valid_num = 1'b0;
      if (m <= v.extra) begin out_valid = 1'b1; out = 4'($urandom); end
      else out_valid = 1'b0;
      if (chk_done === 1'b1) seen = 1'b1;
    end
    chk($sformatf("%s latency", nm), seen ? m : -1, lat);
    chk($sformatf("%s pass", nm), chk_pass, ep);
    chk($sformatf("%s err", nm), chk_err, ee);
    @(posedge clk); #1;
    chk($sformatf("%s pulse_width", nm), chk_done, 1'b0);
    chk($sformatf("%s hold_after", nm), chk_err, ee);
    hold_pass = ep; hold_err = ee;
  endtask

  initial begin
    vec_t v;
    bit mp;
    logic [2:0] me;
    int ml, pulses, var_sel, a;

    for (int c = 0; c < N; c++) L[c] = 4'(base[c]);

    repeat (3) @(posedge clk);
    #1;
    chk("reset done", chk_done, 1'b0);
    chk("reset pass", chk_pass, 1'b0);
    chk("reset err", chk_err, 3'd0);
    rst_n = 1'b1;

    v = dflt(); tbl.push_back(v);
    v = dflt(); v.npre = 2; v.pc[0] = 0; v.pr[0] = 0; v.pc[1] = 3; v.pr[1] = 7;
    v.num = 3'd2; v.send_num = 1'b1; tbl.push_back(v);
    v.pr[1] = 4'd6; v.ep = 1'b0; v.ee = 3'd4; tbl.push_back(v);
    v = dflt(); v.ans[5] = 4'd4; v.ep = 1'b0; v.ee = 3'd3; tbl.push_back(v);
    v = dflt(); v.ans[1] = 4'd1; v.ep = 1'b0; v.ee = 3'd3; tbl.push_back(v);
    v = dflt(); v.nvals = 7; v.ep = 1'b0; v.ee = 3'd1; tbl.push_back(v);
    v = dflt(); v.ans[4] = 4'd13; v.ep = 1'b0; v.ee = 3'd2; tbl.push_back(v);
    v.nvals = 7; v.ee = 3'd1; tbl.push_back(v);
    v = dflt(); v.extra = 3; tbl.push_back(v);
    v = dflt(); v.collide = 1'b1; tbl.push_back(v);
    v = dflt(); v.npre = 2; v.pc[0] = 0; v.pr[0] = 0; v.pc[1] = 3; v.pr[1] = 6;
    v.num = 3'd2; v.send_num = 1'b0; tbl.push_back(v);
    v = dflt(); v.npre = 1; v.pc[0] = 4'd13; v.pr[0] = 0; v.num = 3'd1; v.send_num = 1'b1;
    v.ep = 1'b0; v.ee = 3'd4; tbl.push_back(v);
    v = dflt(); v.npre = 1; v.pc[0] = 3; v.pr[0] = 6; v.num = 3'd0; v.send_num = 1'b1;
    tbl.push_back(v);
    v = dflt(); v.ans[11] = 4'd15; v.ep = 1'b0; v.ee = 3'd2; tbl.push_back(v);
    v = dflt(); v.npre = 9; v.num = 3'd7; v.send_num = 1'b1;
    for (int r = 0; r < 9; r++) begin v.pc[r] = 4'(r); v.pr[r] = L[r]; end
    tbl.push_back(v);

    for (int t = 0; t < tbl.size(); t++) begin
      model(tbl[t], mp, me, ml);
      run(tbl[t], tbl[t].ep, tbl[t].ee, ml, $sformatf("tbl%0d", t));
    end

    // Reset in the middle of pair checking must swallow the verdict.
    for (int n = 0; n < N; n++) begin
      out_valid = 1'b1; out = L[n];
      @(posedge clk); #1;
    end
    out_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    chk("midreset pass", chk_pass, 1'b0);
    chk("midreset err", chk_err, 3'd0);
    pulses = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (chk_done !== 1'b0) pulses++;
    end
    chk("midreset pulses", pulses, 0);
    hold_pass = 1'b0; hold_err = 3'd0;
    v = dflt(); model(v, mp, me, ml);
    run(v, 1'b1, 3'd0, ml, "post_reset");

    for (int t = 0; t < 40; t++) begin
      v = dflt();
      var_sel = int'($urandom_range(0, 3));
      for (int c = 0; c < N; c++) begin
        a = (var_sel[1]) ? int'(L[N - 1 - c]) : int'(L[c]);
        if (var_sel[0]) a = N - 1 - a;
        v.ans[c] = 4'(a);
      end
      if ($urandom_range(0, 1) == 1) v.ans[$urandom_range(0, N - 1)] = 4'($urandom_range(0, N - 1));
      if ($urandom_range(0, 9) == 0) v.ans[$urandom_range(0, N - 1)] = 4'($urandom_range(12, 15));
      if ($urandom_range(0, 7) == 0) v.nvals = int'($urandom_range(1, N - 1));
      v.npre = int'($urandom_range(0, 5));
      for (int r = 0; r < v.npre; r++) begin
        v.pc[r] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(0, N - 1));
        if ($urandom_range(0, 3) == 0) v.pr[r] = 4'($urandom_range(0, N - 1));
        else v.pr[r] = (v.pc[r] < N) ? v.ans[v.pc[r]] : 4'd0;
      end
      v.send_num = ($urandom_range(0, 3) != 0);
      v.num = 3'($urandom_range(0, v.npre));
      v.collide = (v.npre == 0) && ($urandom_range(0, 3) == 0);
      model(v, mp, me, ml);
      if (ml >= 8) v.extra = int'($urandom_range(0, 3));
      run(v, mp, me, ml, $sformatf("rnd%0d", t));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
